// File: rtl/i2s_audio_tx.sv
// I2S transmitter: MCLK/SCLK/LRCLK generation, one-entry sample buffer, 64-SCLK frames.
// Define I2S_UNDERRUN_MUTE_EN to send silence on underrun instead of repeating the last frame.
module i2s_audio_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int MCLK_HALF = 2
) (
    input  logic                CLK_50MHZ,
    input  logic                n_RESET,
    input  logic                EN,
    input  logic [SAMPLE_W-1:0] SAMPLE_L,
    input  logic [SAMPLE_W-1:0] SAMPLE_R,
    input  logic                SAMPLE_VALID,
    output logic                SAMPLE_READY,
    output logic                I2S_MCLK,
    output logic                I2S_SCLK,
    output logic                I2S_LRCLK,
    output logic                I2S_SDIN,
    output logic                UNDERRUN
);

    localparam int DW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_HALF - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    logic [DW-1:0]       r_mdiv;
    logic [1:0]          r_mph;
    logic [5:0]          r_bit;
    logic                r_mclk, r_sclk, r_lrclk, r_sdin, r_underrun;
    logic                r_buf_full;
    logic [SAMPLE_W-1:0] r_buf_l, r_buf_r, r_sr_l, r_sr_r;

    logic                w_tick, w_sclk_fall, w_accept, w_fs, w_sdin_nxt;
    logic [5:0]          w_bit_nxt;
    logic [4:0]          w_b, w_idx;
    logic [SAMPLE_W-1:0] w_chan, w_load_l, w_load_r;
    logic [31:0]         w_pad;

    assign w_tick      = (r_mdiv == DIV_LAST);
    assign w_sclk_fall = w_tick && (r_mph == 2'd3) && r_sclk;
    assign w_accept    = SAMPLE_VALID && !r_buf_full;
    assign w_fs        = EN && ((r_state == S_IDLE) ||
                                (w_sclk_fall && (r_bit == 6'd63)));
    assign w_bit_nxt   = r_bit + 6'd1;

    // Data bit for the slot the counter is about to enter; slot 0 is the I2S delay bit.
    assign w_b        = w_bit_nxt[4:0];
    assign w_chan     = w_bit_nxt[5] ? r_sr_r : r_sr_l;
    assign w_pad      = 32'(w_chan);
    assign w_idx      = 5'(SAMPLE_W) - w_b;
    assign w_sdin_nxt = (w_b != 5'd0) && ({1'b0, w_b} <= 6'(SAMPLE_W)) && w_pad[w_idx];

    always_comb begin
        w_load_l = r_buf_l;
        w_load_r = r_buf_r;
        if (!r_buf_full) begin
`ifdef I2S_UNDERRUN_MUTE_EN
            w_load_l = '0;
            w_load_r = '0;
`else
            w_load_l = r_sr_l;
            w_load_r = r_sr_r;
`endif
        end
    end

    always_ff @(posedge CLK_50MHZ or negedge n_RESET) begin
        if (!n_RESET) begin
            r_state    <= S_IDLE;
            r_mdiv     <= '0;
            r_mph      <= '0;
            r_bit      <= '0;
            r_mclk     <= 1'b0;
            r_sclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdin     <= 1'b0;
            r_underrun <= 1'b0;
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_sr_l     <= '0;
            r_sr_r     <= '0;
        end else begin
            r_underrun <= w_fs && !r_buf_full;
            // A load empties the buffer, but an accept on the same cycle refills it.
            if (w_fs) begin
                r_sr_l     <= w_load_l;
                r_sr_r     <= w_load_r;
                r_buf_full <= w_accept;
            end else if (w_accept) begin
                r_buf_full <= 1'b1;
            end
            if (w_accept) begin
                r_buf_l <= SAMPLE_L;
                r_buf_r <= SAMPLE_R;
            end

            case (r_state)
                S_IDLE: begin
                    if (EN) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!EN) begin
                        r_state <= S_IDLE;
                        r_mdiv  <= '0;
                        r_mph   <= '0;
                        r_bit   <= '0;
                        r_mclk  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_lrclk <= 1'b0;
                        r_sdin  <= 1'b0;
                    end else if (w_tick) begin
                        r_mdiv <= '0;
                        r_mclk <= ~r_mclk;
                        r_mph  <= r_mph + 2'd1;
                        if (r_mph == 2'd3) begin
                            r_sclk <= ~r_sclk;
                            if (r_sclk) begin
                                r_bit   <= w_bit_nxt;
                                r_lrclk <= w_bit_nxt[5];
                                r_sdin  <= w_sdin_nxt;
                            end
                        end
                    end else begin
                        r_mdiv <= r_mdiv + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SAMPLE_READY = !r_buf_full;
    assign I2S_MCLK     = r_mclk;
    assign I2S_SCLK     = r_sclk;
    assign I2S_LRCLK    = r_lrclk;
    assign I2S_SDIN     = r_sdin;
    assign UNDERRUN     = r_underrun;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: frame-level reference model checked every cycle, plus directed frame checks.
// Honours I2S_UNDERRUN_MUTE_EN the same way as the design.
module tb_i2s_audio_tx;

    localparam int W     = 16;
    localparam int H     = 2;
    localparam int FRAME = 512 * H;
`ifdef I2S_UNDERRUN_MUTE_EN
    localparam logic [W-1:0] REP_L = 16'h0000;
    localparam logic [W-1:0] REP_R = 16'h0000;
`else
    localparam logic [W-1:0] REP_L = 16'hA5C3;
    localparam logic [W-1:0] REP_R = 16'h8001;
`endif

    logic         clk = 1'b0;
    logic         n_rst, en, valid;
    logic [W-1:0] sl, sr;
    logic         ready, mclk, sclk, lrclk, sdin, und;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    i2s_audio_tx #(.SAMPLE_W(W), .MCLK_HALF(H)) dut (
        .CLK_50MHZ   (clk),
        .n_RESET     (n_rst),
        .EN          (en),
        .SAMPLE_L    (sl),
        .SAMPLE_R    (sr),
        .SAMPLE_VALID(valid),
        .SAMPLE_READY(ready),
        .I2S_MCLK    (mclk),
        .I2S_SCLK    (sclk),
        .I2S_LRCLK   (lrclk),
        .I2S_SDIN    (sdin),
        .UNDERRUN    (und)
    );

    // Reference model: k counts clocks since RUN entry, everything else follows from k.
    bit           m_run, m_full, m_und, m_acc, m_fs;
    int           m_k;
    logic [W-1:0] m_bl, m_br, m_fl, m_fr;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_run = 0; m_full = 0; m_und = 0; m_k = 0;
            m_bl = '0; m_br = '0; m_fl = '0; m_fr = '0;
        end else begin
            m_acc = valid && !m_full;
            m_fs  = en && (!m_run || ((m_k + 1) % FRAME == 0));
            m_und = m_fs && !m_full;
            if (m_fs) begin
                if (m_full) begin
                    m_fl = m_bl; m_fr = m_br;
                end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
                    m_fl = '0; m_fr = '0;
`endif
                end
                m_full = m_acc;
            end else if (m_acc) begin
                m_full = 1;
            end
            if (m_acc) begin
                m_bl = sl; m_br = sr;
            end
            if (!en) begin
                m_run = 0; m_k = 0;
            end else if (!m_run) begin
                m_run = 1; m_k = 0;
            end else begin
                m_k++;
            end
        end
    end

    logic [5:0]   exp_v, got_v;
    logic [W-1:0] e_s, e_sh;
    int           e_bit, e_b;
    logic         e_mclk, e_sclk, e_lr, e_sdin;

    always @(negedge clk) begin
        if (chk_en) begin
            e_bit  = (m_k / (8 * H)) % 64;
            e_b    = e_bit % 32;
            e_mclk = m_run && ((m_k / H) % 2 == 1);
            e_sclk = m_run && ((m_k / (4 * H)) % 2 == 1);
            e_lr   = m_run && (e_bit >= 32);
            e_s    = (e_bit >= 32) ? m_fr : m_fl;
            e_sh   = e_s >> (W - e_b);
            e_sdin = m_run && (e_b >= 1) && (e_b <= W) && e_sh[0];
            exp_v  = {!m_full, e_mclk, e_sclk, e_lr, e_sdin, m_und};
            got_v  = {ready, mclk, sclk, lrclk, sdin, und};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model k=%0d {rdy,mclk,sclk,lr,sdin,und} got %b exp %b", m_k, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one frame whose first clock edge is the next one; collects the data words.
    task automatic run_frame(output logic [W-1:0] wl, output logic [W-1:0] wr,
                             output bit pad_nz, output bit und0, output bit rdy0, output bit und_other);
        int n;
        wl = '0; wr = '0; pad_nz = 0; und0 = 0; rdy0 = 0; und_other = 0;
        for (int j = 0; j < FRAME; j++) begin
            step(1);
            if (j == 0) begin
                valid = 1'b0;
                und0  = und;
                rdy0  = ready;
            end else if (und) begin
                und_other = 1;
            end
            if (j % (8 * H) == 4 * H) begin
                n = j / (8 * H);
                if (n >= 1 && n <= W) wl = {wl[W-2:0], sdin};
                else if (n >= 33 && n <= 32 + W) wr = {wr[W-2:0], sdin};
                else if (sdin) pad_nz = 1;
            end
            if (j == 1)   chk("mclk_k1", int'(mclk), 0);
            if (j == H)   chk("mclk_kH", int'(mclk), 1);
            if (j == 2*H) chk("mclk_k2H", int'(mclk), 0);
            if (j == 4*H - 1) chk("sclk_pre_rise", int'(sclk), 0);
            if (j == 4*H) chk("sclk_rise", int'(sclk), 1);
            if (j == 8*H) chk("sclk_fall", int'(sclk), 0);
            if (j == FRAME/2 - 1) chk("lrclk_left_end", int'(lrclk), 0);
            if (j == FRAME/2) chk("lrclk_right_start", int'(lrclk), 1);
        end
    endtask

    logic [W-1:0] wl, wr, pl, pr, ql, qr;
    bit           pad_nz, und0, rdy0, und_o;

    initial begin
        n_rst = 1'b0; en = 1'b0; valid = 1'b0; sl = '0; sr = '0;
        step(3);
        chk_en = 1'b1;
        chk("reset_ready", int'(ready), 1);
        chk("reset_outputs", int'({mclk, sclk, lrclk, sdin, und}), 0);
        n_rst = 1'b1;
        step(2);

        sl = 16'hA5C3; sr = 16'h8001; valid = 1'b1;
        step(1);
        valid = 1'b0;
        chk("idle_accept_ready", int'(ready), 0);

        en = 1'b1;
        run_frame(wl, wr, pad_nz, und0, rdy0, und_o);
        chk("f1_left", int'(wl), 16'hA5C3);
        chk("f1_right", int'(wr), 16'h8001);
        chk("f1_padding", int'(pad_nz), 0);
        chk("f1_no_underrun", int'(und0 | und_o), 0);
        chk("f1_ready", int'(rdy0), 1);

        run_frame(wl, wr, pad_nz, und0, rdy0, und_o);
        chk("f2_underrun", int'(und0), 1);
        chk("f2_left", int'(wl), int'(REP_L));
        chk("f2_right", int'(wr), int'(REP_R));

        pl = W'($urandom); pr = W'($urandom);
        sl = pl; sr = pr; valid = 1'b1;
        run_frame(wl, wr, pad_nz, und0, rdy0, und_o);
        chk("f3_underrun", int'(und0), 1);
        chk("f3_ready_drop", int'(rdy0), 0);
        chk("f3_left", int'(wl), int'(REP_L));

        run_frame(wl, wr, pad_nz, und0, rdy0, und_o);
        chk("f4_no_underrun", int'(und0), 0);
        chk("f4_ready", int'(rdy0), 1);
        chk("f4_left", int'(wl), int'(pl));
        chk("f4_right", int'(wr), int'(pr));

        step(100);
        ql = W'($urandom); qr = W'($urandom);
        sl = ql; sr = qr; valid = 1'b1;
        step(1);
        valid = 1'b0;
        step(199);
        en = 1'b0;
        step(1);
        chk("en_drop_outputs", int'({mclk, sclk, lrclk, sdin}), 0);
        chk("en_drop_buffer_kept", int'(ready), 0);
        step(4);
        en = 1'b1;
        run_frame(wl, wr, pad_nz, und0, rdy0, und_o);
        chk("reentry_no_underrun", int'(und0), 0);
        chk("reentry_left", int'(wl), int'(ql));
        chk("reentry_right", int'(wr), int'(qr));

        for (int i = 0; i < 20000; i++) begin
            valid = ($urandom_range(0, 299) == 0);
            sl = W'($urandom); sr = W'($urandom);
            if (en) en = ($urandom_range(0, 3999) != 0);
            else    en = ($urandom_range(0, 19) == 0);
            step(1);
        end
        valid = 1'b0;

        en = 1'b0;
        step(2);
        en = 1'b1;
        step(700);
        chk("pre_reset_right_slot", int'(lrclk), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({mclk, sclk, lrclk, sdin, und}), 0);
        chk("async_reset_ready", int'(ready), 1);
        step(3);
        n_rst = 1'b1;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, sample width in bits; legal range 1..31.
REQ-002 SHALL have parameter MCLK_HALF, default 2, CLK_50MHZ cycles per MCLK half-period; legal range >=1.
REQ-003 SHALL have port CLK_50MHZ  in  1  sole clock; all state rising-edge.
REQ-004 SHALL have port n_RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port EN  in  1  run enable.
REQ-006 SHALL have port SAMPLE_L  in  SAMPLE_W  left sample, two's complement.
REQ-007 SHALL have port SAMPLE_R  in  SAMPLE_W  right sample, two's complement.
REQ-008 SHALL have port SAMPLE_VALID  in  1  SAMPLE_L/SAMPLE_R pair offered.
REQ-009 SHALL have port SAMPLE_READY  out  1  holding buffer empty; pair accepted when VALID&READY.
REQ-010 SHALL have port I2S_MCLK  out  1  master clock.
REQ-011 SHALL have port I2S_SCLK  out  1  bit clock.
REQ-012 SHALL have port I2S_LRCLK  out  1  word select, 0 = left.
REQ-013 SHALL have port I2S_SDIN  out  1  serial data.
REQ-014 SHALL have port UNDERRUN  out  1  one-cycle pulse when a frame starts with empty buffer.

Function
REQ-015 SHALL implement two states: IDLE (counters cleared, I2S outputs 0) and RUN.
REQ-016 IDLE->RUN SHALL occur on the first cycle EN=1; RUN->IDLE SHALL occur on the first cycle EN=0, mid-frame included, with all four I2S outputs 0 on the following cycle.
REQ-017 In RUN, I2S_MCLK SHALL toggle every MCLK_HALF cycles; I2S_SCLK SHALL toggle every 4*MCLK_HALF cycles (SCLK = MCLK/4), first edge rising.
REQ-018 A 6-bit bit counter SHALL increment on each SCLK falling edge, wrapping 63->0; one frame = 64 SCLK = 512*MCLK_HALF cycles (1024 at default).
REQ-019 I2S_LRCLK SHALL equal bit counter bit 5; I2S_LRCLK, I2S_SDIN SHALL change only on SCLK falling edges.
REQ-020 With b = bit counter[4:0], I2S_SDIN SHALL carry shift-register bit (SAMPLE_W-b) of the current channel for 1<=b<=SAMPLE_W, else 0 (I2S one-bit delay, MSB first, zero padding).
REQ-021 Frame start SHALL be the IDLE->RUN cycle and each 63->0 wrap cycle; there the holding buffer SHALL move to the L/R shift registers and the buffer SHALL become empty.
REQ-022 SAMPLE_READY SHALL be 1 exactly when the one-entry holding buffer is empty, in either state.
REQ-023 If the buffer is empty at frame start, UNDERRUN SHALL pulse 1 cycle and the shift registers SHALL take the underrun value (REQ-029/030).
REQ-024 An accept coinciding with frame start SHALL use the pre-cycle buffer state for the load (underrun if empty) and fill the buffer for the next frame.
REQ-025 Buffer full at frame start: the frame loads it and SAMPLE_READY SHALL rise the next cycle.
REQ-026 Accepts in IDLE SHALL fill the buffer; buffer contents SHALL survive RUN->IDLE.

Reset
REQ-027 While n_RESET=0: state IDLE; counters, shift registers, buffer cleared; SAMPLE_READY=1; I2S_MCLK, I2S_SCLK, I2S_LRCLK, I2S_SDIN, UNDERRUN = 0.
REQ-028 Reset deassertion mid-frame SHALL restart from IDLE; first frame after reset emits the buffer value only if a pair was accepted before RUN entry.

Configuration
REQ-029 With macro I2S_UNDERRUN_MUTE_EN defined, underrun load SHALL be all-zero for both channels.
REQ-030 Without I2S_UNDERRUN_MUTE_EN, underrun load SHALL repeat the previous frame's L/R values (zeros if none since reset).

Verification
REQ-031 Reset, EN=1, MCLK_HALF=2: MCLK period 4 cycles, SCLK period 16, LRCLK period 1024, LRCLK low first 512 cycles.
REQ-032 Accept L=16'hA5C3, R=16'h8001 in IDLE, then EN=1 -> left slot b=1..16 shows 1010010111000011, b=17..31 zero; right slot 1000000000000001; no UNDERRUN.
REQ-033 No VALID after first frame -> UNDERRUN pulse at cycle 1024; SDIN all-zero (mute build) or A5C3/8001 repeated (default build).
REQ-034 VALID asserted exactly on a frame-start cycle with empty buffer -> UNDERRUN pulses, SAMPLE_READY drops next cycle, pair appears in following frame.
REQ-035 EN dropped at cycle 300 -> all I2S outputs 0 next cycle; EN re-raised -> LRCLK restarts low, buffered pair loaded at that cycle.
REQ-036 n_RESET asserted mid-right-channel -> all outputs at reset values same cycle, SAMPLE_READY=1.
